// File: rtl/kl_arb_queue.sv
// kl_arb_queue
// ------------
// KL-bus request concentrator. NCH independent request channels each feed a
// DEPTH-entry first-word-fall-through queue. A round-robin arbiter with a
// handshake lock forwards queue heads to a single memory port. Every issued
// request (read or write) returns exactly one in-order response, which is
// routed back to the originating channel via an OUTS-entry order FIFO of
// channel indices.
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   s_req_*              per-channel request fields, channel i packed at
//                        [W*i +: W]; s_req_ready[i] = queue i not full
//   s_resp_*             response fields broadcast to all channels,
//                        s_resp_valid is one-hot on the destination channel
//   m_req_*              memory-side request port (fields from queue head)
//   m_resp_*             memory-side response port
//   outstanding          issued requests still awaiting a response
//   err_unexpected_resp  sticky flag: response arrived with nothing pending

module kl_arb_queue #(
  parameter int NCH   = 2,
  parameter int DEPTH = 2,
  parameter int OUTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*32-1:0]     s_req_addr,
  input  logic [NCH-1:0]        s_req_wen,
  input  logic [NCH*64-1:0]     s_req_wdata,
  input  logic [NCH*8-1:0]      s_req_wmask,
  input  logic [NCH*3-1:0]      s_req_size,
  input  logic [NCH*5-1:0]      s_req_srcid,
  input  logic [NCH-1:0]        s_req_valid,
  output logic [NCH-1:0]        s_req_ready,
  output logic [63:0]           s_resp_rdata,
  output logic                  s_resp_ren,
  output logic [2:0]            s_resp_size,
  output logic [4:0]            s_resp_dstid,
  output logic [NCH-1:0]        s_resp_valid,
  input  logic [NCH-1:0]        s_resp_ready,
  output logic [31:0]           m_req_addr,
  output logic                  m_req_wen,
  output logic [63:0]           m_req_wdata,
  output logic [7:0]            m_req_wmask,
  output logic [2:0]            m_req_size,
  output logic [4:0]            m_req_srcid,
  output logic                  m_req_valid,
  input  logic                  m_req_ready,
  input  logic [63:0]           m_resp_rdata,
  input  logic                  m_resp_ren,
  input  logic [2:0]            m_resp_size,
  input  logic [4:0]            m_resp_dstid,
  input  logic                  m_resp_valid,
  output logic                  m_resp_ready,
  output logic [$clog2(OUTS):0] outstanding,
  output logic                  err_unexpected_resp
);

  // Widths: channel index, queue pointer/count, order FIFO pointer/count.
  // Pointers keep at least one bit so DEPTH=1 / OUTS=1 / NCH=1 still elaborate.
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int QPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QCW = $clog2(DEPTH) + 1;
  localparam int OPW = (OUTS > 1) ? $clog2(OUTS) : 1;
  localparam int OCW = $clog2(OUTS) + 1;
  // Packed request entry: addr, wen, wdata, wmask, size, srcid
  localparam int RW  = 32 + 1 + 64 + 8 + 3 + 5;

  // Pointer increment with wrap for non-power-of-two-safe behaviour.
  function automatic logic [QPW-1:0] qInc(input logic [QPW-1:0] p);
    if (p == QPW'(DEPTH - 1)) return '0;
    else return p + 1'b1;
  endfunction

  function automatic logic [OPW-1:0] oInc(input logic [OPW-1:0] p);
    if (p == OPW'(OUTS - 1)) return '0;
    else return p + 1'b1;
  endfunction

  // Channel queue state
  logic [RW-1:0]  qMem_q [NCH][DEPTH];
  logic [QPW-1:0] qRd_q  [NCH];
  logic [QPW-1:0] qRd_d  [NCH];
  logic [QPW-1:0] qWr_q  [NCH];
  logic [QPW-1:0] qWr_d  [NCH];
  logic [QCW-1:0] qCnt_q [NCH];
  logic [QCW-1:0] qCnt_d [NCH];
  logic [RW-1:0]  qIn    [NCH];
  logic [RW-1:0]  qHead  [NCH];
  logic [NCH-1:0] qFull;
  logic [NCH-1:0] qEmpty;
  logic [NCH-1:0] qPush;
  logic [NCH-1:0] qPop;

  // Arbiter state
  logic [CW-1:0]  rrPtr_q, rrPtr_d;
  logic           lock_q, lock_d;
  logic [CW-1:0]  lockCh_q, lockCh_d;
  logic [CW-1:0]  rrSel;
  logic [CW-1:0]  rrIdx;
  logic           rrFound;
  logic [CW-1:0]  sel;
  logic           reqFire;

  // Order FIFO state
  logic [CW-1:0]  ordMem_q [OUTS];
  logic [OPW-1:0] ordRd_q, ordRd_d;
  logic [OPW-1:0] ordWr_q, ordWr_d;
  logic [OCW-1:0] ordCnt_q, ordCnt_d;
  logic           ordEmpty;
  logic [CW-1:0]  ordHead;
  logic           respFire;
  logic           errUnexp_q, errUnexp_d;

  // Queue status and push decode. Ready is forced low during reset so an
  // upstream master never sees a handshake that the reset then discards.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      qIn[i]    = {s_req_addr[i*32 +: 32], s_req_wen[i],
                   s_req_wdata[i*64 +: 64], s_req_wmask[i*8 +: 8],
                   s_req_size[i*3 +: 3], s_req_srcid[i*5 +: 5]};
      qHead[i]  = qMem_q[i][qRd_q[i]];
      qFull[i]  = (qCnt_q[i] == QCW'(DEPTH));
      qEmpty[i] = (qCnt_q[i] == '0);
      s_req_ready[i] = !qFull[i] && !rst;
      qPush[i]  = s_req_valid[i] && s_req_ready[i];
    end
  end

  // Queue pointer and occupancy next-state; push and pop may coincide.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      qRd_d[i]  = qPop[i] ? qInc(qRd_q[i]) : qRd_q[i];
      qWr_d[i]  = qPush[i] ? qInc(qWr_q[i]) : qWr_q[i];
      qCnt_d[i] = qCnt_q[i] + QCW'(qPush[i]) - QCW'(qPop[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        qRd_q[i]  <= '0;
        qWr_q[i]  <= '0;
        qCnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        qRd_q[i]  <= qRd_d[i];
        qWr_q[i]  <= qWr_d[i];
        qCnt_q[i] <= qCnt_d[i];
      end
    end
  end

  // Queue storage carries no reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (qPush[i]) qMem_q[i][qWr_q[i]] <= qIn[i];
    end
  end

  // Round-robin search from rrPtr. While a request is stalled at memory the
  // lock pins the selection so the presented fields cannot change under it.
  always_comb begin
    rrSel   = rrPtr_q;
    rrIdx   = '0;
    rrFound = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      rrIdx = CW'((int'(rrPtr_q) + k) % NCH);
      if (!rrFound && !qEmpty[rrIdx]) begin
        rrSel   = rrIdx;
        rrFound = 1'b1;
      end
    end

    sel         = lock_q ? lockCh_q : rrSel;
    m_req_valid = rrFound && (ordCnt_q < OCW'(OUTS));
    reqFire     = m_req_valid && m_req_ready;

    {m_req_addr, m_req_wen, m_req_wdata, m_req_wmask, m_req_size,
     m_req_srcid} = qHead[sel];

    for (int i = 0; i < NCH; i++) begin
      qPop[i] = reqFire && (sel == CW'(i));
    end

    rrPtr_d  = rrPtr_q;
    lock_d   = lock_q;
    lockCh_d = lockCh_q;
    if (reqFire) begin
      rrPtr_d = (sel == CW'(NCH - 1)) ? '0 : sel + 1'b1;
      lock_d  = 1'b0;
    end else if (m_req_valid) begin
      lock_d   = 1'b1;
      lockCh_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_q  <= '0;
      lock_q   <= 1'b0;
      lockCh_q <= '0;
    end else begin
      rrPtr_q  <= rrPtr_d;
      lock_q   <= lock_d;
      lockCh_q <= lockCh_d;
    end
  end

  // Response routing. With nothing outstanding the beat is accepted and
  // dropped so a stray response can never wedge the memory side.
  always_comb begin
    ordEmpty     = (ordCnt_q == '0);
    ordHead      = ordMem_q[ordRd_q];
    s_resp_valid = '0;
    for (int i = 0; i < NCH; i++) begin
      s_resp_valid[i] = m_resp_valid && !ordEmpty && (ordHead == CW'(i));
    end
    m_resp_ready = ordEmpty ? 1'b1 : s_resp_ready[ordHead];
    respFire     = m_resp_valid && m_resp_ready && !ordEmpty;

    ordRd_d    = respFire ? oInc(ordRd_q) : ordRd_q;
    ordWr_d    = reqFire ? oInc(ordWr_q) : ordWr_q;
    ordCnt_d   = ordCnt_q + OCW'(reqFire) - OCW'(respFire);
    errUnexp_d = errUnexp_q || (m_resp_valid && ordEmpty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ordRd_q    <= '0;
      ordWr_q    <= '0;
      ordCnt_q   <= '0;
      errUnexp_q <= 1'b0;
    end else begin
      ordRd_q    <= ordRd_d;
      ordWr_q    <= ordWr_d;
      ordCnt_q   <= ordCnt_d;
      errUnexp_q <= errUnexp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reqFire) ordMem_q[ordWr_q] <= sel;
  end

  assign s_resp_rdata        = m_resp_rdata;
  assign s_resp_ren          = m_resp_ren;
  assign s_resp_size         = m_resp_size;
  assign s_resp_dstid        = m_resp_dstid;
  assign outstanding         = ordCnt_q;
  assign err_unexpected_resp = errUnexp_q;

endmodule

// File: tb/tb_kl_arb_queue.sv
// tb_kl_arb_queue
// ---------------
// Testbench for kl_arb_queue (NCH=2, DEPTH=2, OUTS=4). Directed scenario
// tasks followed by a randomized run checked against a queue-based model.

module tb_kl_arb_queue;

  localparam int NCH   = 2;
  localparam int DEPTH = 2;
  localparam int OUTS  = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [2:0]  size;
    logic [4:0]  srcid;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  logic [NCH*32-1:0] s_req_addr;
  logic [NCH-1:0]    s_req_wen;
  logic [NCH*64-1:0] s_req_wdata;
  logic [NCH*8-1:0]  s_req_wmask;
  logic [NCH*3-1:0]  s_req_size;
  logic [NCH*5-1:0]  s_req_srcid;
  logic [NCH-1:0]    s_req_valid;
  logic [NCH-1:0]    s_req_ready;
  logic [63:0]       s_resp_rdata;
  logic              s_resp_ren;
  logic [2:0]        s_resp_size;
  logic [4:0]        s_resp_dstid;
  logic [NCH-1:0]    s_resp_valid;
  logic [NCH-1:0]    s_resp_ready;
  logic [31:0]       m_req_addr;
  logic              m_req_wen;
  logic [63:0]       m_req_wdata;
  logic [7:0]        m_req_wmask;
  logic [2:0]        m_req_size;
  logic [4:0]        m_req_srcid;
  logic              m_req_valid;
  logic              m_req_ready;
  logic [63:0]       m_resp_rdata;
  logic              m_resp_ren;
  logic [2:0]        m_resp_size;
  logic [4:0]        m_resp_dstid;
  logic              m_resp_valid;
  logic              m_resp_ready;
  logic [$clog2(OUTS):0] outstanding;
  logic              err_unexpected_resp;

  int nChecks = 0;
  int nPassed = 0;

  // 10 ns clock
  always #5 clk = ~clk;

  kl_arb_queue #(.NCH(NCH), .DEPTH(DEPTH), .OUTS(OUTS)) dut (
    .clk(clk), .rst(rst),
    .s_req_addr(s_req_addr), .s_req_wen(s_req_wen),
    .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
    .s_req_size(s_req_size), .s_req_srcid(s_req_srcid),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_resp_rdata(s_resp_rdata), .s_resp_ren(s_resp_ren),
    .s_resp_size(s_resp_size), .s_resp_dstid(s_resp_dstid),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
    .m_req_addr(m_req_addr), .m_req_wen(m_req_wen),
    .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_req_size(m_req_size), .m_req_srcid(m_req_srcid),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_resp_rdata(m_resp_rdata), .m_resp_ren(m_resp_ren),
    .m_resp_size(m_resp_size), .m_resp_dstid(m_resp_dstid),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .outstanding(outstanding), .err_unexpected_resp(err_unexpected_resp)
  );

  // Advance to just after the next rising edge; inputs change here and
  // outputs are sampled one more #1 later, well away from either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic req_t mkReq(input logic [31:0] a, input logic w,
                                 input logic [63:0] d, input logic [4:0] sid);
    req_t r;
    r.addr  = a;
    r.wen   = w;
    r.wdata = d;
    r.wmask = 8'hFF;
    r.size  = 3'd3;
    r.srcid = sid;
    return r;
  endfunction

  // Place one request on a channel's slice of the packed input vectors.
  task automatic driveReq(input int ch, input req_t r);
    s_req_addr[ch*32 +: 32]  = r.addr;
    s_req_wen[ch]            = r.wen;
    s_req_wdata[ch*64 +: 64] = r.wdata;
    s_req_wmask[ch*8 +: 8]   = r.wmask;
    s_req_size[ch*3 +: 3]    = r.size;
    s_req_srcid[ch*5 +: 5]   = r.srcid;
  endtask

  task automatic idleInputs();
    s_req_addr = '0; s_req_wen = '0; s_req_wdata = '0; s_req_wmask = '0;
    s_req_size = '0; s_req_srcid = '0; s_req_valid = '0;
    s_resp_ready = '0; m_req_ready = 1'b0;
    m_resp_rdata = '0; m_resp_ren = 1'b0; m_resp_size = '0;
    m_resp_dstid = '0; m_resp_valid = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reset held with all channels requesting: nothing may be accepted.
  task automatic test_reset();
    idleInputs();
    rst = 1'b1;
    s_req_valid = '1;
    driveReq(0, mkReq(32'hA0, 1'b0, 64'h1, 5'd1));
    driveReq(1, mkReq(32'hB0, 1'b0, 64'h2, 5'd2));
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      nChecks++; if (s_req_ready !== 2'b00) $display("[TB] FAIL rst_ready: got %b want 00", s_req_ready); else nPassed++;
      nChecks++; if (m_req_valid !== 1'b0) $display("[TB] FAIL rst_mvalid: got %b want 0", m_req_valid); else nPassed++;
      nChecks++; if (outstanding !== 3'd0) $display("[TB] FAIL rst_outst: got %0d want 0", outstanding); else nPassed++;
      tick();
    end
    rst = 1'b0;
    s_req_valid = '0;
    #1;
    nChecks++; if (s_req_ready !== 2'b11) $display("[TB] FAIL post_rst_ready: got %b want 11", s_req_ready); else nPassed++;
    nChecks++; if (m_req_valid !== 1'b0) $display("[TB] FAIL post_rst_mvalid: got %b want 0", m_req_valid); else nPassed++;
    nChecks++; if (err_unexpected_resp !== 1'b0) $display("[TB] FAIL post_rst_err: got %b want 0", err_unexpected_resp); else nPassed++;
    nChecks++; if (s_resp_valid !== 2'b00) $display("[TB] FAIL post_rst_svalid: got %b want 00", s_resp_valid); else nPassed++;
  endtask

  // Fill ch0 while memory stalls, then drain: FIFO order and full behaviour.
  task automatic test_single_channel();
    doReset();
    s_req_valid = 2'b01;
    driveReq(0, mkReq(32'h100, 1'b0, 64'h0, 5'd0));
    #1;
    nChecks++; if (s_req_ready[0] !== 1'b1) $display("[TB] FAIL sc_ready1: got %b want 1", s_req_ready[0]); else nPassed++;
    tick();
    driveReq(0, mkReq(32'h108, 1'b0, 64'h0, 5'd0));
    #1;
    nChecks++; if (s_req_ready[0] !== 1'b1) $display("[TB] FAIL sc_ready2: got %b want 1", s_req_ready[0]); else nPassed++;
    nChecks++; if (m_req_addr !== 32'h100 || m_req_valid !== 1'b1) $display("[TB] FAIL sc_first: got %h/%b want 100/1", m_req_addr, m_req_valid); else nPassed++;
    tick();
    driveReq(0, mkReq(32'h110, 1'b0, 64'h0, 5'd0));
    #1;
    nChecks++; if (s_req_ready[0] !== 1'b0) $display("[TB] FAIL sc_full: got %b want 0", s_req_ready[0]); else nPassed++;
    tick();
    #1;
    nChecks++; if (s_req_ready[0] !== 1'b0) $display("[TB] FAIL sc_full_hold: got %b want 0", s_req_ready[0]); else nPassed++;
    m_req_ready = 1'b1;
    #1;
    nChecks++; if (m_req_addr !== 32'h100 || m_req_valid !== 1'b1) $display("[TB] FAIL sc_rel0: got %h/%b want 100/1", m_req_addr, m_req_valid); else nPassed++;
    tick();
    #1;
    nChecks++; if (m_req_addr !== 32'h108 || m_req_valid !== 1'b1) $display("[TB] FAIL sc_rel1: got %h/%b want 108/1", m_req_addr, m_req_valid); else nPassed++;
    nChecks++; if (s_req_ready[0] !== 1'b1) $display("[TB] FAIL sc_refill: got %b want 1", s_req_ready[0]); else nPassed++;
    tick();
    s_req_valid = 2'b00;
    #1;
    nChecks++; if (m_req_addr !== 32'h110 || m_req_valid !== 1'b1) $display("[TB] FAIL sc_rel2: got %h/%b want 110/1", m_req_addr, m_req_valid); else nPassed++;
    tick();
    m_req_ready = 1'b0;
    #1;
    nChecks++; if (m_req_valid !== 1'b0) $display("[TB] FAIL sc_drained: got %b want 0", m_req_valid); else nPassed++;
    nChecks++; if (outstanding !== 3'd3) $display("[TB] FAIL sc_outst: got %0d want 3", outstanding); else nPassed++;
  endtask

  // Both channels saturated; memory answers so the outstanding limit never
  // throttles. Grants must alternate starting at ch0 (srcid = channel).
  task automatic test_fairness();
    doReset();
    m_req_ready = 1'b1;
    s_resp_ready = 2'b11;
    driveReq(0, mkReq(32'h10, 1'b0, 64'h0, 5'd0));
    driveReq(1, mkReq(32'h20, 1'b0, 64'h0, 5'd1));
    s_req_valid = 2'b11;
    tick();
    for (int g = 0; g < 8; g++) begin
      m_resp_valid = (g > 0);
      #1;
      nChecks++; if (m_req_valid !== 1'b1 || m_req_srcid !== 5'(g % 2)) $display("[TB] FAIL fair_grant%0d: got ch%0d/v%b want ch%0d/v1", g, m_req_srcid, m_req_valid, g % 2); else nPassed++;
      tick();
    end
    m_resp_valid = 1'b0;
    s_req_valid = 2'b00;
    #1;
    nChecks++; if (err_unexpected_resp !== 1'b0) $display("[TB] FAIL fair_err: got %b want 0", err_unexpected_resp); else nPassed++;
  endtask

  // After a ch0 grant, rr favours ch1; a stalled ch0 request must stay put
  // even when ch1 becomes non-empty.
  task automatic test_lock();
    doReset();
    m_req_ready = 1'b1;
    s_req_valid = 2'b01;
    driveReq(0, mkReq(32'h200, 1'b0, 64'h0, 5'd0));
    tick();
    driveReq(0, mkReq(32'h208, 1'b0, 64'h0, 5'd0));
    #1;
    nChecks++; if (m_req_addr !== 32'h200 || m_req_valid !== 1'b1) $display("[TB] FAIL lock_pre: got %h/%b want 200/1", m_req_addr, m_req_valid); else nPassed++;
    tick();
    m_req_ready = 1'b0;
    s_req_valid = 2'b10;
    driveReq(1, mkReq(32'h300, 1'b0, 64'h0, 5'd1));
    #1;
    nChecks++; if (m_req_addr !== 32'h208 || m_req_valid !== 1'b1) $display("[TB] FAIL lock_stall: got %h/%b want 208/1", m_req_addr, m_req_valid); else nPassed++;
    tick();
    s_req_valid = 2'b00;
    for (int c = 0; c < 2; c++) begin
      #1;
      nChecks++; if (m_req_addr !== 32'h208 || m_req_srcid !== 5'd0) $display("[TB] FAIL lock_hold%0d: got %h/ch%0d want 208/ch0", c, m_req_addr, m_req_srcid); else nPassed++;
      tick();
    end
    m_req_ready = 1'b1;
    #1;
    nChecks++; if (m_req_addr !== 32'h208) $display("[TB] FAIL lock_release: got %h want 208", m_req_addr); else nPassed++;
    tick();
    #1;
    nChecks++; if (m_req_addr !== 32'h300 || m_req_srcid !== 5'd1) $display("[TB] FAIL lock_next: got %h/ch%0d want 300/ch1", m_req_addr, m_req_srcid); else nPassed++;
    tick();
    m_req_ready = 1'b0;
  endtask

  // Five back-to-back ch0 requests, no responses: the fifth waits until one
  // response frees an order-FIFO slot.
  task automatic test_outstanding_limit();
    doReset();
    m_req_ready = 1'b1;
    s_req_valid = 2'b01;
    for (int c = 0; c < 5; c++) begin
      driveReq(0, mkReq(32'h400 + 32'(8 * c), 1'b0, 64'h0, 5'd0));
      #1;
      if (c > 0) begin
        nChecks++; if (m_req_valid !== 1'b1 || m_req_addr !== 32'h400 + 32'(8 * (c - 1))) $display("[TB] FAIL ol_issue%0d: got %h/%b want %h/1", c, m_req_addr, m_req_valid, 32'h400 + 32'(8 * (c - 1))); else nPassed++;
      end
      tick();
    end
    s_req_valid = 2'b00;
    for (int c = 0; c < 2; c++) begin
      #1;
      nChecks++; if (m_req_valid !== 1'b0) $display("[TB] FAIL ol_blocked%0d: got %b want 0", c, m_req_valid); else nPassed++;
      nChecks++; if (outstanding !== 3'd4) $display("[TB] FAIL ol_full%0d: got %0d want 4", c, outstanding); else nPassed++;
      tick();
    end
    m_resp_valid = 1'b1;
    s_resp_ready = 2'b11;
    #1;
    nChecks++; if (m_resp_ready !== 1'b1 || s_resp_valid !== 2'b01) $display("[TB] FAIL ol_resp: got rdy%b/sv%b want 1/01", m_resp_ready, s_resp_valid); else nPassed++;
    tick();
    m_resp_valid = 1'b0;
    #1;
    nChecks++; if (outstanding !== 3'd3) $display("[TB] FAIL ol_after_resp: got %0d want 3", outstanding); else nPassed++;
    nChecks++; if (m_req_valid !== 1'b1 || m_req_addr !== 32'h420) $display("[TB] FAIL ol_fifth: got %h/%b want 420/1", m_req_addr, m_req_valid); else nPassed++;
    tick();
    m_req_ready = 1'b0;
    #1;
    nChecks++; if (outstanding !== 3'd4) $display("[TB] FAIL ol_refull: got %0d want 4", outstanding); else nPassed++;
  endtask

  // ch1 read then ch0 write; responses return in that order, and a busy
  // ch1 holds back both the memory port and the later ch0 response.
  task automatic test_routing();
    doReset();
    m_req_ready = 1'b1;
    s_resp_ready = 2'b11;
    s_req_valid = 2'b10;
    driveReq(1, mkReq(32'h500, 1'b0, 64'h0, 5'd5));
    tick();
    s_req_valid = 2'b01;
    driveReq(0, mkReq(32'h600, 1'b1, 64'hDEAD_BEEF_0123_4567, 5'd2));
    #1;
    nChecks++; if (m_req_srcid !== 5'd5 || m_req_wen !== 1'b0) $display("[TB] FAIL rt_req1: got sid%0d/w%b want 5/0", m_req_srcid, m_req_wen); else nPassed++;
    tick();
    s_req_valid = 2'b00;
    #1;
    nChecks++; if (m_req_srcid !== 5'd2 || m_req_wen !== 1'b1 || m_req_wdata !== 64'hDEAD_BEEF_0123_4567) $display("[TB] FAIL rt_req2: got sid%0d/w%b/%h want 2/1/deadbeef01234567", m_req_srcid, m_req_wen, m_req_wdata); else nPassed++;
    tick();
    m_req_ready = 1'b0;
    m_resp_valid = 1'b1;
    m_resp_dstid = 5'd5;
    m_resp_ren = 1'b1;
    m_resp_rdata = 64'h1122_3344_5566_7788;
    s_resp_ready = 2'b01;
    #1;
    nChecks++; if (outstanding !== 3'd2) $display("[TB] FAIL rt_outst: got %0d want 2", outstanding); else nPassed++;
    nChecks++; if (s_resp_valid !== 2'b10) $display("[TB] FAIL rt_resp1_valid: got %b want 10", s_resp_valid); else nPassed++;
    nChecks++; if (m_resp_ready !== 1'b0) $display("[TB] FAIL rt_stall: got %b want 0", m_resp_ready); else nPassed++;
    nChecks++; if (s_resp_dstid !== 5'd5 || s_resp_rdata !== 64'h1122_3344_5566_7788) $display("[TB] FAIL rt_fields: got %0d/%h want 5/1122334455667788", s_resp_dstid, s_resp_rdata); else nPassed++;
    tick();
    #1;
    nChecks++; if (s_resp_valid !== 2'b10 || outstanding !== 3'd2) $display("[TB] FAIL rt_stall_hold: got %b/%0d want 10/2", s_resp_valid, outstanding); else nPassed++;
    s_resp_ready = 2'b11;
    #1;
    nChecks++; if (m_resp_ready !== 1'b1) $display("[TB] FAIL rt_unstall: got %b want 1", m_resp_ready); else nPassed++;
    tick();
    m_resp_dstid = 5'd2;
    m_resp_ren = 1'b0;
    #1;
    nChecks++; if (s_resp_valid !== 2'b01 || s_resp_ren !== 1'b0) $display("[TB] FAIL rt_resp2: got %b/ren%b want 01/0", s_resp_valid, s_resp_ren); else nPassed++;
    tick();
    m_resp_valid = 1'b0;
    #1;
    nChecks++; if (outstanding !== 3'd0 || err_unexpected_resp !== 1'b0) $display("[TB] FAIL rt_done: got %0d/err%b want 0/0", outstanding, err_unexpected_resp); else nPassed++;
  endtask

  // Stray response with nothing pending, and a response after a reset that
  // discarded an outstanding request.
  task automatic test_unexpected();
    doReset();
    m_resp_valid = 1'b1;
    #1;
    nChecks++; if (m_resp_ready !== 1'b1 || s_resp_valid !== 2'b00) $display("[TB] FAIL ux_accept: got rdy%b/sv%b want 1/00", m_resp_ready, s_resp_valid); else nPassed++;
    nChecks++; if (err_unexpected_resp !== 1'b0) $display("[TB] FAIL ux_not_yet: got %b want 0", err_unexpected_resp); else nPassed++;
    tick();
    m_resp_valid = 1'b0;
    #1;
    nChecks++; if (err_unexpected_resp !== 1'b1) $display("[TB] FAIL ux_set: got %b want 1", err_unexpected_resp); else nPassed++;
    tick();
    tick();
    #1;
    nChecks++; if (err_unexpected_resp !== 1'b1) $display("[TB] FAIL ux_sticky: got %b want 1", err_unexpected_resp); else nPassed++;
    doReset();
    #1;
    nChecks++; if (err_unexpected_resp !== 1'b0) $display("[TB] FAIL ux_cleared: got %b want 0", err_unexpected_resp); else nPassed++;
    m_req_ready = 1'b1;
    s_req_valid = 2'b01;
    driveReq(0, mkReq(32'h700, 1'b0, 64'h0, 5'd7));
    tick();
    s_req_valid = 2'b00;
    tick();
    #1;
    nChecks++; if (outstanding !== 3'd1) $display("[TB] FAIL ux_pending: got %0d want 1", outstanding); else nPassed++;
    doReset();
    m_resp_valid = 1'b1;
    s_resp_ready = 2'b11;
    #1;
    nChecks++; if (s_resp_valid !== 2'b00 || m_resp_ready !== 1'b1 || outstanding !== 3'd0) $display("[TB] FAIL ux_midrst: got sv%b/rdy%b/o%0d want 00/1/0", s_resp_valid, m_resp_ready, outstanding); else nPassed++;
    tick();
    m_resp_valid = 1'b0;
    #1;
    nChecks++; if (err_unexpected_resp !== 1'b1) $display("[TB] FAIL ux_midrst_err: got %b want 1", err_unexpected_resp); else nPassed++;
  endtask

  // Randomized traffic against a model built from plain queues: one FIFO of
  // requests per channel, one FIFO of pending channel indices, a "next
  // channel to favour" index and a remembered stalled channel.
  task automatic test_random();
    req_t mq[NCH][$];
    int   ordQ[$];
    int   rrNext;
    bit   locked;
    int   lockCh;
    bit   errExp;
    req_t reqIn[NCH];
    logic [NCH-1:0] expReady;
    logic [NCH-1:0] expSv;
    logic expMr;
    logic expMv;
    int   sel;
    int   h;
    req_t dutReq;

    doReset();
    for (int i = 0; i < NCH; i++) mq[i].delete();
    ordQ.delete();
    rrNext = 0;
    locked = 1'b0;
    lockCh = 0;
    errExp = 1'b0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NCH; i++) begin
        reqIn[i] = mkReq($urandom, 1'($urandom), {$urandom, $urandom}, 5'($urandom));
        reqIn[i].wmask = 8'($urandom);
        reqIn[i].size  = 3'($urandom);
        driveReq(i, reqIn[i]);
        s_req_valid[i]  = ($urandom % 4) != 0;
        s_resp_ready[i] = ($urandom % 4) != 0;
      end
      m_req_ready  = ($urandom % 3) != 0;
      m_resp_valid = (ordQ.size() > 0) ? 1'($urandom) : (($urandom % 50) == 0);
      m_resp_rdata = {$urandom, $urandom};
      m_resp_ren   = 1'($urandom);
      m_resp_size  = 3'($urandom);
      m_resp_dstid = 5'($urandom);
      #1;

      for (int i = 0; i < NCH; i++) expReady[i] = mq[i].size() < DEPTH;
      sel = -1;
      if (locked) sel = lockCh;
      else begin
        for (int k = 0; k < NCH; k++) begin
          if (sel < 0 && mq[(rrNext + k) % NCH].size() > 0) sel = (rrNext + k) % NCH;
        end
      end
      expMv = (sel >= 0) && (ordQ.size() < OUTS);
      expSv = '0;
      h = 0;
      if (ordQ.size() == 0) expMr = 1'b1;
      else begin
        h = ordQ[0];
        expMr = s_resp_ready[h];
        if (m_resp_valid) expSv[h] = 1'b1;
      end

      nChecks++; if (s_req_ready !== expReady) $display("[TB] FAIL rnd_ready c%0d: got %b want %b", cyc, s_req_ready, expReady); else nPassed++;
      nChecks++; if (m_req_valid !== expMv) $display("[TB] FAIL rnd_mvalid c%0d: got %b want %b", cyc, m_req_valid, expMv); else nPassed++;
      if (expMv) begin
        dutReq = {m_req_addr, m_req_wen, m_req_wdata, m_req_wmask, m_req_size, m_req_srcid};
        nChecks++; if (dutReq !== mq[sel][0]) $display("[TB] FAIL rnd_mreq c%0d: got %h want %h", cyc, dutReq, mq[sel][0]); else nPassed++;
      end
      nChecks++; if (s_resp_valid !== expSv) $display("[TB] FAIL rnd_svalid c%0d: got %b want %b", cyc, s_resp_valid, expSv); else nPassed++;
      nChecks++; if (m_resp_ready !== expMr) $display("[TB] FAIL rnd_mready c%0d: got %b want %b", cyc, m_resp_ready, expMr); else nPassed++;
      nChecks++; if (outstanding !== 3'(ordQ.size())) $display("[TB] FAIL rnd_outst c%0d: got %0d want %0d", cyc, outstanding, ordQ.size()); else nPassed++;
      nChecks++; if (err_unexpected_resp !== errExp) $display("[TB] FAIL rnd_err c%0d: got %b want %b", cyc, err_unexpected_resp, errExp); else nPassed++;

      if (m_resp_valid && ordQ.size() == 0) errExp = 1'b1;
      if (m_resp_valid && ordQ.size() > 0 && s_resp_ready[h]) void'(ordQ.pop_front());
      if (expMv && m_req_ready) begin
        void'(mq[sel].pop_front());
        ordQ.push_back(sel);
        rrNext = (sel + 1) % NCH;
        locked = 1'b0;
      end else if (expMv) begin
        locked = 1'b1;
        lockCh = sel;
      end
      for (int i = 0; i < NCH; i++) begin
        if (s_req_valid[i] && expReady[i]) mq[i].push_back(reqIn[i]);
      end
      tick();
    end
    idleInputs();
  endtask

  // Scenario sequence and summary
  initial begin
    rst = 1'b1;
    idleInputs();
    test_reset();
    test_single_channel();
    test_fairness();
    test_lock();
    test_outstanding_limit();
    test_routing();
    test_unexpected();
    test_random();
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
